// File: rtl/morse_keyer_if.sv
// Character handshake between the mode/controller side and the Morse keyer.
// The master offers codes; the slave accepts them when it is idle.
interface morse_keyer_if;
  logic       char_valid;
  logic [5:0] char_code;
  logic       char_ready;

  modport master (
    output char_valid,
    output char_code,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_code,
    output char_ready
  );
endinterface

// File: rtl/morse_keyer.sv
// Morse keyer: plays one character code as timed on/off keying on key_out.
// Marks, gaps and spaces are counted in units of UNIT_CYCLES clock cycles.
module morse_keyer #(
  parameter int UNIT_CYCLES = 10_000_000,
  parameter int CW          = $clog2(UNIT_CYCLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  morse_keyer_if.slave cif,
  output logic         key_out,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    GAP,
    LGAP,
    SPACE
  } state_t;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } glyph_t;

  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

  // Symbols are left-aligned: the first symbol sits in pat[4], 1 = dash.
  function automatic glyph_t rom(input logic [5:0] c);
    glyph_t g;
    g = '0;
    case (c)
      6'd0:  g = {3'd2, 5'b01000};
      6'd1:  g = {3'd4, 5'b10000};
      6'd2:  g = {3'd4, 5'b10100};
      6'd3:  g = {3'd3, 5'b10000};
      6'd4:  g = {3'd1, 5'b00000};
      6'd5:  g = {3'd4, 5'b00100};
      6'd6:  g = {3'd3, 5'b11000};
      6'd7:  g = {3'd4, 5'b00000};
      6'd8:  g = {3'd2, 5'b00000};
      6'd9:  g = {3'd4, 5'b01110};
      6'd10: g = {3'd3, 5'b10100};
      6'd11: g = {3'd4, 5'b01000};
      6'd12: g = {3'd2, 5'b11000};
      6'd13: g = {3'd2, 5'b10000};
      6'd14: g = {3'd3, 5'b11100};
      6'd15: g = {3'd4, 5'b01100};
      6'd16: g = {3'd4, 5'b11010};
      6'd17: g = {3'd3, 5'b01000};
      6'd18: g = {3'd3, 5'b00000};
      6'd19: g = {3'd1, 5'b10000};
      6'd20: g = {3'd3, 5'b00100};
      6'd21: g = {3'd4, 5'b00010};
      6'd22: g = {3'd3, 5'b01100};
      6'd23: g = {3'd4, 5'b10010};
      6'd24: g = {3'd4, 5'b10110};
      6'd25: g = {3'd4, 5'b11000};
      6'd26: g = {3'd5, 5'b11111};
      6'd27: g = {3'd5, 5'b01111};
      6'd28: g = {3'd5, 5'b00111};
      6'd29: g = {3'd5, 5'b00011};
      6'd30: g = {3'd5, 5'b00001};
      6'd31: g = {3'd5, 5'b00000};
      6'd32: g = {3'd5, 5'b10000};
      6'd33: g = {3'd5, 5'b11000};
      6'd34: g = {3'd5, 5'b11100};
      6'd35: g = {3'd5, 5'b11110};
      default: g = '0;
    endcase
    return g;
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [1:0]    units, units_n;
  logic [2:0]    idx, idx_n;
  logic [5:0]    code_q, code_n;
  logic          ready;
  logic          done_n, err_n;
  logic          accept, tick, dash;
  logic [1:0]    need;
  glyph_t        g;

  assign cif.char_ready = ready;
  assign accept = cif.char_valid && ready;
  assign tick   = (cyc == LAST);
  assign g      = rom(code_q);
  assign dash   = g.pat[3'd4 - idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cyc    <= '0;
      units  <= '0;
      idx    <= '0;
      code_q <= '0;
    end else begin
      state  <= state_n;
      cyc    <= cyc_n;
      units  <= units_n;
      idx    <= idx_n;
      code_q <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    units_n = units;
    idx_n   = idx;
    code_n  = code_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    // Last unit index (0-based) each timed state waits for.
    unique case (state)
      MARK:    need = dash ? 2'd2 : 2'd0;
      LGAP:    need = 2'd2;
      SPACE:   need = 2'd3;
      default: need = 2'd0;
    endcase
    if (state == IDLE) begin
      if (accept) begin
        code_n  = cif.char_code;
        cyc_n   = '0;
        units_n = '0;
        idx_n   = '0;
        unique case (1'b1)
          (cif.char_code < 6'd36):  state_n = MARK;
          (cif.char_code == 6'd36): state_n = SPACE;
          default:                  err_n   = 1'b1;
        endcase
      end
    end else if (tick && units == need) begin
      cyc_n   = '0;
      units_n = '0;
      unique case (state)
        MARK: state_n = (idx + 3'd1 < g.len) ? GAP : LGAP;
        GAP: begin
          idx_n   = idx + 3'd1;
          state_n = MARK;
        end
        default: begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      endcase
    end else if (tick) begin
      cyc_n   = '0;
      units_n = units + 2'd1;
    end else begin
      cyc_n = cyc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      key_out <= (state_n == MARK);
      ready   <= (state_n == IDLE);
      busy    <= (state_n != IDLE);
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: table vectors, hand sequences and random codes
// checked against a dot/dash string model of the keying waveform.
module tb_morse_keyer;

  localparam int U = 4;

  logic clk;
  logic rst_n;
  logic key_out, busy, done, err;

  morse_keyer_if cif ();

  morse_keyer #(.UNIT_CYCLES(U)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cif     (cif),
    .key_out (key_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  string syms [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
    "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  bit expq[$];

  typedef struct {
    int code;
    int busy_cyc;
    int mark_cyc;
    bit bad;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected key_out per cycle after acceptance, from the dot/dash string.
  task automatic build_exp(input int code);
    string s;
    expq.delete();
    if (code == 36) begin
      repeat (4 * U) expq.push_back(1'b0);
      return;
    end
    s = syms[code];
    for (int i = 0; i < s.len(); i++) begin
      int m;
      m = (s[i] == "-") ? 3 : 1;
      repeat (m * U) expq.push_back(1'b1);
      if (i != s.len() - 1) repeat (U) expq.push_back(1'b0);
    end
    repeat (3 * U) expq.push_back(1'b0);
  endtask

  task automatic play(input int code, input bit hold, input int nxt);
    int n;
    build_exp(code);
    n = expq.size();
    chk("ready_pre", int'(cif.char_ready), 1);
    cif.char_valid = 1'b1;
    cif.char_code  = 6'(code);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("key c%0d k%0d", code, k + 1), int'(key_out), int'(expq[k]));
      chk("busy_on", int'(busy), 1);
      chk("ready_off", int'(cif.char_ready), 0);
      chk("done_off", int'(done), 0);
      chk("err_off", int'(err), 0);
      if (hold) begin
        cif.char_valid = 1'b1;
        cif.char_code  = 6'(nxt);
      end else begin
        cif.char_valid = 1'($urandom_range(0, 1));
        cif.char_code  = 6'($urandom_range(0, 63));
      end
    end
    @(negedge clk);
    chk($sformatf("done c%0d", code), int'(done), 1);
    chk("ready_done", int'(cif.char_ready), 1);
    chk("busy_done", int'(busy), 0);
    chk("key_done", int'(key_out), 0);
    chk("err_done", int'(err), 0);
    if (!hold) cif.char_valid = 1'b0;
  endtask

  task automatic play_bad(input int code);
    chk("ready_pre_bad", int'(cif.char_ready), 1);
    cif.char_valid = 1'b1;
    cif.char_code  = 6'(code);
    @(posedge clk);
    @(negedge clk);
    cif.char_valid = 1'b0;
    chk($sformatf("err c%0d", code), int'(err), 1);
    chk("bad_ready", int'(cif.char_ready), 1);
    chk("bad_key", int'(key_out), 0);
    chk("bad_done", int'(done), 0);
    chk("bad_busy", int'(busy), 0);
    @(negedge clk);
    chk("err_single", int'(err), 0);
    chk("bad_ready2", int'(cif.char_ready), 1);
    chk("bad_done2", int'(done), 0);
  endtask

  task automatic measure(input vec_t v, input int id);
    int bc, mc, ec, dn, lim;
    bc = 0; mc = 0; ec = 0; dn = 0;
    lim = v.bad ? 6 : 200;
    chk($sformatf("tbl%0d_ready", id), int'(cif.char_ready), 1);
    cif.char_valid = 1'b1;
    cif.char_code  = 6'(v.code);
    @(posedge clk);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      cif.char_valid = 1'b0;
      bc += int'(busy);
      mc += int'(key_out);
      ec += int'(err);
      if (done) begin
        dn = 1;
        break;
      end
    end
    chk($sformatf("tbl%0d_busy_cycles", id), bc, v.busy_cyc);
    chk($sformatf("tbl%0d_mark_cycles", id), mc, v.mark_cyc);
    chk($sformatf("tbl%0d_err_count", id), ec, int'(v.bad));
    chk($sformatf("tbl%0d_done_seen", id), dn, int'(!v.bad));
  endtask

  initial begin
    vt[0] = '{4, 16, 4, 1'b0};
    vt[1] = '{0, 32, 16, 1'b0};
    vt[2] = '{19, 24, 12, 1'b0};
    vt[3] = '{16, 64, 40, 1'b0};
    vt[4] = '{26, 88, 60, 1'b0};
    vt[5] = '{31, 48, 20, 1'b0};
    vt[6] = '{35, 80, 52, 1'b0};
    vt[7] = '{36, 16, 0, 1'b0};
    vt[8] = '{40, 0, 0, 1'b1};
    vt[9] = '{63, 0, 0, 1'b1};

    cif.char_valid = 1'b0;
    cif.char_code  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_key", int'(key_out), 0);
    chk("rst_ready", int'(cif.char_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(cif.char_ready), 1);

    for (int i = 0; i < 10; i++) measure(vt[i], i);

    play(4, 1'b0, 0);
    play(0, 1'b0, 0);
    play(36, 1'b0, 0);
    play_bad(40);

    play(4, 1'b1, 19);
    play(19, 1'b0, 0);

    chk("r5_ready", int'(cif.char_ready), 1);
    cif.char_valid = 1'b1;
    cif.char_code  = 6'd31;
    @(posedge clk);
    @(negedge clk);
    cif.char_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("r5_third_mark", int'(key_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r5_key_drop", int'(key_out), 0);
    chk("r5_ready", int'(cif.char_ready), 1);
    chk("r5_busy", int'(busy), 0);
    chk("r5_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("r5_no_done", int'(done), 0);
      chk("r5_idle_key", int'(key_out), 0);
    end
    play(4, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      int c;
      c = int'($urandom_range(0, 63));
      if (c > 36) play_bad(c);
      else play(c, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
